// File: rtl/peripheral_uart_pkg.sv
// Shared types and constants for the UART transmit path.
package peripheral_uart_pkg;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned TICK_W        = $clog2(TICKS_PER_BIT);
  localparam int unsigned BIT_CNT_W     = 3;
  localparam int unsigned LCR_W         = 8;

  localparam int unsigned LCR_WL_LO = 0;
  localparam int unsigned LCR_WL_HI = 1;
  localparam int unsigned LCR_SB    = 2;
  localparam int unsigned LCR_PE    = 3;
  localparam int unsigned LCR_EP    = 4;
  localparam int unsigned LCR_SP    = 5;
  localparam int unsigned LCR_BC    = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP1  = 3'd5,
    S_STOP2  = 3'd6
  } tx_state_e;

endpackage

// File: rtl/peripheral_uart_parity_wb.sv
// Parity bit for one character; bits above the configured word length are ignored.
module peripheral_uart_parity_wb
  import peripheral_uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic [LCR_W-1:0]  lcr,
  output logic              parity_c
);

  logic [3:0]        word_len;
  logic [DATA_W-1:0] active;
  logic              p;

  assign word_len = 4'd5 + 4'(lcr[LCR_WL_HI:LCR_WL_LO]);

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      active[i] = data[i] && (i < 32'(word_len));
    end
  end

  assign p        = ^active;
  assign parity_c = lcr[LCR_SP] ? ~lcr[LCR_EP] : (lcr[LCR_EP] ? p : ~p);

endmodule

// File: rtl/peripheral_uart_transmitter_wb.sv
// UART transmit controller: pops the TX FIFO and serialises each character.
// Define PERIPHERAL_UART_TX_HALFSTOP_EN for 1.5 stop bits on 5-bit words with two stop bits.
module peripheral_uart_transmitter_wb
  import peripheral_uart_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH     = 8,
  parameter int unsigned FIFO_COUNTER_W = 5
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      enable,
  input  logic [LCR_W-1:0]          lcr,
  input  logic                      tx_reset,
  input  logic [FIFO_COUNTER_W-1:0] tf_count,
  input  logic [FIFO_WIDTH-1:0]     tf_data_in,
  output logic                      tf_pop,
  output logic                      stx_pad_o,
  output logic [2:0]                tstate,
  output logic                      tx_busy,
  output logic                      tx_empty
);

  tx_state_e             state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [FIFO_WIDTH-1:0] shift_reg;
  logic                  parity_q;
  logic                  stx_q;

  logic                  parity_c;
  logic                  more_c;
  logic                  bit_end_c;
  logic [BIT_CNT_W-1:0]  last_bit_c;
  logic [TICK_W-1:0]     stop2_last_c;

  peripheral_uart_parity_wb #(
    .DATA_W (FIFO_WIDTH)
  ) u_parity (
    .data     (tf_data_in),
    .lcr      (lcr),
    .parity_c (parity_c)
  );

  assign more_c     = (tf_count != '0);
  assign last_bit_c = BIT_CNT_W'(32'd4 + 32'(lcr[LCR_WL_HI:LCR_WL_LO]));

`ifdef PERIPHERAL_UART_TX_HALFSTOP_EN
  assign stop2_last_c = (lcr[LCR_WL_HI:LCR_WL_LO] == 2'b00) ? TICK_W'(TICKS_PER_BIT / 2 - 1)
                                                             : TICK_W'(TICKS_PER_BIT - 1);
`else
  assign stop2_last_c = TICK_W'(TICKS_PER_BIT - 1);
`endif

  assign bit_end_c = enable &&
                     (tick_cnt == ((state == S_STOP2) ? stop2_last_c : TICK_W'(TICKS_PER_BIT - 1)));

  // Frame sequencer; stx_q is loaded with the level of the state being entered.
  always_ff @(posedge clk) begin
    if (!wb_rst_i || tx_reset) begin
      state     <= S_IDLE;
      stx_q     <= 1'b1;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (more_c) state <= S_POP;
        end
        S_POP: begin
          shift_reg <= tf_data_in;
          parity_q  <= parity_c;
          tick_cnt  <= '0;
          stx_q     <= 1'b0;
          state     <= S_START;
        end
        default: begin
          if (enable) tick_cnt <= bit_end_c ? '0 : tick_cnt + TICK_W'(1);
          if (bit_end_c) begin
            case (state)
              S_START: begin
                state   <= S_DATA;
                bit_cnt <= '0;
                stx_q   <= shift_reg[0];
              end
              S_DATA: begin
                // >= keeps the FSM moving if lcr shrinks the word mid-frame
                if (bit_cnt >= last_bit_c) begin
                  if (lcr[LCR_PE]) begin
                    state <= S_PARITY;
                    stx_q <= parity_q;
                  end else begin
                    state <= S_STOP1;
                    stx_q <= 1'b1;
                  end
                end else begin
                  bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                  shift_reg <= shift_reg >> 1;
                  stx_q     <= shift_reg[1];
                end
              end
              S_PARITY: begin
                state <= S_STOP1;
                stx_q <= 1'b1;
              end
              S_STOP1: begin
                if (lcr[LCR_SB]) state <= S_STOP2;
                else             state <= more_c ? S_POP : S_IDLE;
              end
              default: begin
                state <= more_c ? S_POP : S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tf_pop    = (state == S_POP);
  assign stx_pad_o = lcr[LCR_BC] ? 1'b0 : stx_q;
  assign tstate    = state;
  assign tx_busy   = (state != S_IDLE);
  assign tx_empty  = (state == S_IDLE) && !more_c;

endmodule

// File: tb/tb_peripheral_uart_transmitter_wb.sv
// Bench for the UART transmitter: tick-level frame model plus directed literal checks.
module tb_peripheral_uart_transmitter_wb;

  localparam int unsigned FIFO_WIDTH     = 8;
  localparam int unsigned FIFO_COUNTER_W = 5;
`ifdef PERIPHERAL_UART_TX_HALFSTOP_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      wb_rst_i = 1'b0;
  logic                      enable = 1'b0;
  logic [7:0]                lcr = 8'h03;
  logic                      tx_reset = 1'b0;
  logic [FIFO_COUNTER_W-1:0] tf_count;
  logic [FIFO_WIDTH-1:0]     tf_data_in;
  logic                      tf_pop;
  logic                      stx_pad_o;
  logic [2:0]                tstate;
  logic                      tx_busy;
  logic                      tx_empty;

  peripheral_uart_transmitter_wb #(
    .FIFO_WIDTH     (FIFO_WIDTH),
    .FIFO_COUNTER_W (FIFO_COUNTER_W)
  ) dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .enable     (enable),
    .lcr        (lcr),
    .tx_reset   (tx_reset),
    .tf_count   (tf_count),
    .tf_data_in (tf_data_in),
    .tf_pop     (tf_pop),
    .stx_pad_o  (stx_pad_o),
    .tstate     (tstate),
    .tx_busy    (tx_busy),
    .tx_empty   (tx_empty)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] q[$];
  logic exp_lvl[$];
  int   exp_st[$];
  int   m_phase = 0;          // 0 idle, 1 popping, 2 sending a frame
  bit   chk_on = 1'b0;
  bit   log_on = 1'b0;
  logic dlog[$];
  int   pop_cnt = 0;
  int   en_gap = 0;
  logic pop_now;
  logic e_lvl;
  int   e_st;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    tf_count   = FIFO_COUNTER_W'(q.size());
    tf_data_in = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    refresh();
  endtask

  function automatic void add_bit(input logic v, input int st, input int n);
    repeat (n) begin
      exp_lvl.push_back(v);
      exp_st.push_back(st);
    end
  endfunction

  // Expand one character into its per-tick line level and state code.
  function automatic void build_frame(input logic [7:0] d, input logic [7:0] l);
    int   nb;
    logic p;
    nb = 5 + int'(l[1:0]);
    p  = 1'b0;
    for (int i = 0; i < nb; i++) p ^= d[i];
    exp_lvl.delete();
    exp_st.delete();
    add_bit(1'b0, 2, 16);
    for (int i = 0; i < nb; i++) add_bit(d[i], 3, 16);
    if (l[3]) add_bit(l[5] ? ~l[4] : (l[4] ? p : ~p), 4, 16);
    add_bit(1'b1, 5, 16);
    if (l[2]) add_bit(1'b1, 6, (HALF && l[1:0] == 2'b00) ? 8 : 16);
  endfunction

  // 16x tick: one cycle high, then 1-2 cycles low
  initial begin
    forever begin
      @(posedge clk); #1;
      if (en_gap == 0) begin
        enable = 1'b1;
        en_gap = $urandom_range(1, 2);
      end else begin
        enable = 1'b0;
        en_gap--;
      end
    end
  end

  // FIFO model: pops after the edge on which the DUT strobed tf_pop
  always @(posedge clk) begin
    pop_now = tf_pop;
    #1;
    if (pop_now) begin
      chk("pop_nonempty", int'(q.size() != 0), 1);
      if (q.size() != 0) void'(q.pop_front());
      refresh();
    end
  end

  // Reference model advance
  always @(posedge clk) begin
    if (!wb_rst_i || tx_reset) begin
      m_phase = 0;
      exp_lvl.delete();
      exp_st.delete();
    end else begin
      case (m_phase)
        0: if (tf_count != 0) m_phase = 1;
        1: begin
          build_frame((q.size() != 0) ? q[0] : 8'h00, lcr);
          m_phase = 2;
        end
        default: if (enable) begin
          void'(exp_lvl.pop_front());
          void'(exp_st.pop_front());
          if (exp_lvl.size() == 0) m_phase = (tf_count != 0) ? 1 : 0;
        end
      endcase
    end
  end

  // Cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      e_st  = (m_phase == 0) ? 0 : (m_phase == 1) ? 1 : exp_st[0];
      e_lvl = (m_phase == 2) ? exp_lvl[0] : 1'b1;
      if (lcr[6]) e_lvl = 1'b0;
      chk("stx", int'(stx_pad_o), int'(e_lvl));
      chk("tf_pop", int'(tf_pop), int'(m_phase == 1));
      chk("tstate", int'(tstate), e_st);
      chk("tx_busy", int'(tx_busy), int'(m_phase != 0));
      chk("tx_empty", int'(tx_empty), int'(m_phase == 0 && tf_count == 0));
    end
    if (tf_pop) pop_cnt++;
    if (log_on && enable && tx_busy && !tf_pop) dlog.push_back(stx_pad_o);
  end

  task automatic wait_empty(input int maxc, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(tx_empty && q.size() == 0) && k < maxc);
    chk({nm, "_done"}, int'(tx_empty && q.size() == 0), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_pop(input int maxc, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tf_pop && k < maxc);
    chk({nm, "_pop_seen"}, int'(tf_pop), 1);
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (enable) k++;
    end
  endtask

  // One character; pat[k] is the line level expected mid-way through bit k.
  task automatic run_frame(input logic [7:0] l, input logic [7:0] d, input string nm,
                           input int exp_len, input logic [15:0] pat, input int nbits);
    int p0;
    lcr = l;
    dlog.delete();
    p0 = pop_cnt;
    log_on = 1'b1;
    push(d);
    wait_empty(3000, nm);
    log_on = 1'b0;
    chk({nm, "_ticks"}, dlog.size(), exp_len);
    for (int k = 0; k < nbits; k++) begin
      if (16 * k + 8 < dlog.size()) chk({nm, "_bit"}, int'(dlog[16 * k + 8]), int'(pat[k]));
      else chk({nm, "_bit_missing"}, -1, int'(pat[k]));
    end
    chk({nm, "_pops"}, pop_cnt - p0, 1);
    chk({nm, "_tx_empty"}, int'(tx_empty), 1);
  endtask

  initial begin
    int p0, k, gaps, n;
    bit seen;
    refresh();
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stx", int'(stx_pad_o), 1);
    chk("rst_tstate", int'(tstate), 0);
    chk("rst_pop", int'(tf_pop), 0);
    chk("rst_empty", int'(tx_empty), 1);
    @(posedge clk); #1;
    wb_rst_i = 1'b1;
    repeat (3) @(posedge clk); #1;

    run_frame(8'h03, 8'hA5, "8n1", 160, 16'(10'b1101001010), 10);
    run_frame(8'h1E, 8'h53, "7e2", 176, 16'(11'b11010100110), 11);
    run_frame(8'h04, 8'h1F, "5n2", HALF ? 120 : 128, 16'(7'b1111110), 7);

    // Back-to-back frames
    lcr = 8'h03;
    p0 = pop_cnt;
    push(8'h11); push(8'hEE); push(8'h5A);
    k = 0; gaps = 0; seen = 1'b0;
    while (!(tx_empty && q.size() == 0) && k < 8000) begin
      @(negedge clk);
      k++;
      if (tf_pop) seen = 1'b1;
      if (seen && !tx_busy && q.size() != 0) gaps++;
    end
    chk("b2b_done", int'(tx_empty && q.size() == 0), 1);
    chk("b2b_pops", pop_cnt - p0, 3);
    chk("b2b_busy_gaps", gaps, 0);
    @(posedge clk); #1;

    // Abort in the 4th data bit
    push(8'hC3);
    wait_pop(100, "abort");
    @(posedge clk);
    wait_ticks(16 + 48 + 4);
    #1;
    tx_reset = 1'b1;
    q.delete();
    refresh();
    @(posedge clk); #1;
    tx_reset = 1'b0;
    @(negedge clk);
    chk("abort_tstate", int'(tstate), 0);
    chk("abort_stx", int'(stx_pad_o), 1);
    p0 = pop_cnt;
    repeat (100) @(negedge clk);
    chk("abort_no_pop", pop_cnt - p0, 0);
    @(posedge clk); #1;

    // Reset while sending parity
    lcr = 8'h0B;
    push(8'h3C);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tstate != 3'd4 && k < 3000);
    chk("parity_reached", int'(tstate), 4);
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("rst_par_stx", int'(stx_pad_o), 1);
    chk("rst_par_tstate", int'(tstate), 0);
    wb_rst_i = 1'b1;
    @(posedge clk); #1;

    // Break during a frame
    lcr = 8'h03;
    p0 = pop_cnt;
    push(8'h96); push(8'h69);
    wait_pop(100, "brk");
    @(posedge clk);
    wait_ticks(40);
    #1;
    lcr = 8'h43;
    repeat (10) begin
      @(negedge clk);
      chk("brk_stx", int'(stx_pad_o), 0);
    end
    @(posedge clk); #1;
    lcr = 8'h03;
    wait_empty(6000, "brk");
    chk("brk_pops", pop_cnt - p0, 2);

    // Random framing and bursts
    for (int it = 0; it < 12; it++) begin
      lcr = 8'($urandom_range(0, 63));
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      wait_empty(9000, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/peripheral_uart_transmitter_wb.md
Name: peripheral_uart_transmitter_wb

Overview:
Transmit controller for the UART: drains the transmit FIFO one character at a time and serialises each character onto the TX pad.
- Frame: start bit, 5-8 data bits LSB first, optional parity bit, 1 or 2 stop bits. The line control register (LCR) value selects the framing.
- Baud timing comes from a 16x oversample tick generated elsewhere in the UART core.
- Sits between the TX FIFO (this block is its only popper) and the pad; exports status bits to the register block.

Parameters:
FIFO_WIDTH, 8, character width held in the FIFO
FIFO_COUNTER_W, 5, width of the FIFO occupancy count

Ports:
clk  input  1  system clock; all logic on rising edge
wb_rst_i  input  1  synchronous, active-low reset
enable  input  1  16x baud tick, one clk cycle wide
lcr  input  8  [1:0] word length (00=5 .. 11=8), [2] two stop bits, [3] parity enable, [4] even parity, [5] stick parity, [6] break
tx_reset  input  1  synchronous abort of the current character (FCR TX reset)
tf_count  input  FIFO_COUNTER_W  TX FIFO occupancy
tf_data_in  input  FIFO_WIDTH  TX FIFO head data (combinational read of the bottom entry)
tf_pop  output  1  one-cycle pop strobe to the TX FIFO
stx_pad_o  output  1  serial output; idle high
tstate  output  3  FSM state encoding, for debug/status
tx_busy  output  1  high when state != IDLE
tx_empty  output  1  high when state == IDLE and tf_count == 0 (TEMT)

Behaviour:
- Reset (wb_rst_i==0 at a clock edge): state IDLE, stx_pad_o=1, tf_pop=0, tick and bit counters 0, shift register 0. This also applies mid-frame; no partial bits follow.
- tx_reset=1: same effect as reset on the FSM and stx_pad_o. Takes priority over enable. The FIFO is cleared externally.
- State encodings (tstate): IDLE=0, POP=1, START=2, DATA=3, PARITY=4, STOP1=5, STOP2=6.
- IDLE: if tf_count != 0, go to POP on the next edge; no enable is required. Otherwise stay.
- POP: lasts exactly one cycle, and tf_pop=1 only in this state (decoded from the registered state). At the end of the cycle:
  - shift_reg <= tf_data_in;
  - parity bit is computed and stored;
  - go to START.
- Bit timing: each bit lasts 16 enable ticks. A 4-bit tick counter is cleared on entry to each bit state. The state advances on the edge where enable=1 and the counter==15.
- START: stx=0.
- DATA:
  - stx=shift_reg[0]; shift right at each bit end.
  - Bit counter runs 0 .. (4+lcr[1:0]).
  - After the last data bit, go to PARITY if lcr[3], else STOP1.
- Parity, computed over the active data bits only (bits above the word length are masked to 0). Let P = XOR of active data bits.
  - Stick (lcr[5]=1): parity bit = ~lcr[4].
  - Even (lcr[4]=1): parity bit = P.
  - Odd: parity bit = ~P.
- STOP1: stx=1. Then STOP2 if lcr[2], else end of frame.
- STOP2: stx=1 for 16 ticks. Then end of frame.
- End of frame: go to POP if tf_count != 0 (back-to-back, no idle gap), else IDLE.
- lcr is sampled live. Software changes framing only while tx_empty=1; a mid-frame change is undefined framing but the FSM never locks up.
- Break: lcr[6]=1 forces stx_pad_o=0 combinationally over the FSM output. The FSM continues to run and pop.
- stx_pad_o is registered except for the break override.
- A pop is never issued when tf_count==0.

Optional Feature:
PERIPHERAL_UART_TX_HALFSTOP_EN
- Defined: when lcr[1:0]==00 and lcr[2]==1, STOP2 lasts 8 ticks (1.5 stop bits, 16550 behaviour).
- Undefined: STOP2 always lasts 16 ticks.

Decomposition:
- Shared package peripheral_uart_pkg holds:
  - state enum typedef;
  - LCR bit-index localparams (LCR_WL_LO/HI, LCR_SB, LCR_PE, LCR_EP, LCR_SP, LCR_BC);
  - TICKS_PER_BIT=16.
- One natural sub-module: peripheral_uart_parity_wb, combinational; inputs data + lcr, output parity bit.

Test Plan:
- 8N1: lcr=0x03, FIFO holds 0xA5 → one tf_pop pulse; stx=0 for 16 ticks, then bits 1,0,1,0,0,1,0,1 at 16 ticks each, then 1 for 16 ticks; tx_empty=1 afterwards.
- 7E2: lcr=0x1E, byte 0x53 → 7 data bits 1,1,0,0,1,0,1, parity 0, then stop bits for 32 ticks; bit 7 is never transmitted.
- Back-to-back: FIFO count=3 → exactly 3 tf_pop pulses, each 1 cycle; no idle high between the stop bit and the next start bit; tx_busy stays high until the 3rd frame ends.
- Abort: tx_reset pulsed during the 4th data bit → next cycle tstate=0 and stx=1; no further pop until tf_count != 0.
- Reset and break:
  - wb_rst_i=0 mid-PARITY → stx=1 and tstate=0 on the next edge.
  - lcr[6]=1 during a frame → stx=0 while set; the frame still completes and pops correctly.
- Half-stop (macro defined): lcr=0x04, byte 0x1F → stop period is 24 ticks; with the macro undefined it is 32.
